// File: rtl/commit_pkg.sv
// Shared encodings and defaults for the in-order commit unit.
package commit_pkg;

  localparam int unsigned ROB_WIDTH_DEFAULT    = 4;
  localparam int unsigned FLUSH_CYCLES_DEFAULT = 2;
  localparam int unsigned TYPE_W               = 2;
  localparam int unsigned REG_W                = 5;
  localparam int unsigned DATA_W               = 32;

  // Instruction class reported by the ROB head
  typedef enum logic [TYPE_W-1:0] {
    TYPE_ALU    = 2'd0,
    TYPE_STORE  = 2'd1,
    TYPE_BRANCH = 2'd2,
    TYPE_HALT   = 2'd3
  } head_type_e;

  // Retirement controller states
  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_WAIT_STORE = 2'd1,
    ST_FLUSH      = 2'd2,
    ST_HALTED     = 2'd3
  } commit_state_e;

endpackage

// File: rtl/commit_unit.sv
// In-order retirement: pops the ROB head, writes the register file one cycle
// later, releases stores through an LSB handshake and redirects on mispredict.
module commit_unit
  import commit_pkg::*;
#(
  parameter int unsigned ROB_WIDTH    = ROB_WIDTH_DEFAULT,
  parameter int unsigned FLUSH_CYCLES = FLUSH_CYCLES_DEFAULT
) (
  input  logic                 clockIn,
  input  logic                 resetIn,
  input  logic                 headValid,
  input  logic                 headReady,
  input  logic [TYPE_W-1:0]    headType,
  input  logic [ROB_WIDTH-1:0] headRobId,
  input  logic [REG_W-1:0]     headDest,
  input  logic [DATA_W-1:0]    headValue,
  input  logic                 headMispredict,
  input  logic [DATA_W-1:0]    headTarget,
  output logic                 headPop,
  output logic                 regUpdateValid,
  output logic [REG_W-1:0]     regUpdateDest,
  output logic [DATA_W-1:0]    regUpdateValue,
  output logic [ROB_WIDTH-1:0] regUpdateRobId,
  output logic                 storeCommitValid,
  output logic [ROB_WIDTH-1:0] storeCommitRobId,
  input  logic                 storeCommitAck,
  output logic                 clearOut,
  output logic                 pcRedirectValid,
  output logic [DATA_W-1:0]    pcRedirect,
  output logic                 halted,
  output logic [DATA_W-1:0]    retiredCount
);

  localparam int unsigned CNT_W = $clog2(FLUSH_CYCLES + 1);

  commit_state_e          state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  head_type_e             head_type;
  logic                   can_retire;

  logic                   reg_vld_d;
  logic [REG_W-1:0]       reg_dest_d;
  logic [DATA_W-1:0]      reg_val_d;
  logic [ROB_WIDTH-1:0]   reg_id_d;
  logic                   st_vld_d;
  logic [ROB_WIDTH-1:0]   st_id_d;
  logic                   clr_d;
  logic [DATA_W-1:0]      redir_d;
  logic                   halted_d;

  assign head_type  = head_type_e'(headType);
  assign can_retire = headValid && headReady;

  // Next state, combinational pop and next values of the registered outputs
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    headPop    = 1'b0;
    reg_vld_d  = 1'b0;
    reg_dest_d = '0;
    reg_val_d  = '0;
    reg_id_d   = '0;
    st_vld_d   = 1'b0;
    st_id_d    = '0;
    clr_d      = 1'b0;
    redir_d    = '0;
    halted_d   = halted;

    case (state_q)
      ST_RUN: begin
        if (can_retire) begin
          case (head_type)
            TYPE_STORE: begin
              // Store stays in the ROB until the LSB accepts the release
              st_vld_d = 1'b1;
              st_id_d  = headRobId;
              state_d  = ST_WAIT_STORE;
            end
            TYPE_HALT: begin
              headPop  = 1'b1;
              halted_d = 1'b1;
              state_d  = ST_HALTED;
            end
            default: begin
              // ALU/LOAD and branches retire with an optional register write
              headPop = 1'b1;
              if (headDest != '0) begin
                reg_vld_d  = 1'b1;
                reg_dest_d = headDest;
                reg_val_d  = headValue;
                reg_id_d   = headRobId;
              end
              if ((head_type == TYPE_BRANCH) && headMispredict) begin
                clr_d   = 1'b1;
                redir_d = headTarget;
                cnt_d   = CNT_W'(FLUSH_CYCLES);
                state_d = ST_FLUSH;
              end
            end
          endcase
        end
      end
      ST_WAIT_STORE: begin
        if (storeCommitAck) begin
          headPop = 1'b1;
          state_d = ST_RUN;
        end else begin
          st_vld_d = 1'b1;
          st_id_d  = storeCommitRobId;
        end
      end
      ST_FLUSH: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_RUN;
        end
      end
      ST_HALTED: begin
        state_d = ST_HALTED;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // State and drain counter
  always_ff @(posedge clockIn or negedge resetIn) begin
    if (!resetIn) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Registered retirement outputs and the retire counter
  always_ff @(posedge clockIn or negedge resetIn) begin
    if (!resetIn) begin
      regUpdateValid   <= 1'b0;
      regUpdateDest    <= '0;
      regUpdateValue   <= '0;
      regUpdateRobId   <= '0;
      storeCommitValid <= 1'b0;
      storeCommitRobId <= '0;
      clearOut         <= 1'b0;
      pcRedirectValid  <= 1'b0;
      pcRedirect       <= '0;
      halted           <= 1'b0;
      retiredCount     <= '0;
    end else begin
      regUpdateValid   <= reg_vld_d;
      regUpdateDest    <= reg_dest_d;
      regUpdateValue   <= reg_val_d;
      regUpdateRobId   <= reg_id_d;
      storeCommitValid <= st_vld_d;
      storeCommitRobId <= st_id_d;
      clearOut         <= clr_d;
      pcRedirectValid  <= clr_d;
      pcRedirect       <= redir_d;
      halted           <= halted_d;
      retiredCount     <= retiredCount + DATA_W'(headPop);
    end
  end

endmodule
